pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Central pipeline controller for the 5-stage core. Arbitrates per-stage stall
//  requests into stall[5:0] for the PC and the if_id/id_ex/ex_mem/mem_wb
//  registers. Raises flush and the redirect PC on exceptions and ERET.
//  Also provides a debug halt/resume sequence, a stall watchdog and
//  saturating stall/flush performance counters.
// PARAMETERS
//  EXC_VECTOR     32'h0000_0020  redirect PC for every non-ERET exception
//  ERET_CODE      32'h0000_000e  excepttype value that denotes ERET
//  STALL_TIMEOUT  1024           consecutive stalled cycles that set stall_timeout
//  CNT_W          32             width of the performance counters
// PORTS
//  clk            in   1      clock
//  rst            in   1      reset: synchronous, active-high
//  stallreq_if    in   1      fetch stage waiting on the instruction bus
//  stallreq_id    in   1      decode load-use hazard
//  stallreq_ex    in   1      execute multi-cycle op (div/madd) busy
//  stallreq_mem   in   1      memory stage waiting on the data bus
//  excepttype     in   32     exception code from the mem stage, 0 = none
//  cp0_epc        in   32     current EPC from CP0, used for ERET
//  halt_req       in   1      debug halt request, level-sensitive
//  stall          out  6      [0]pc [1]if [2]id [3]ex [4]mem [5]wb, 1 = hold
//  flush          out  1      clear all pipeline registers at next edge
//  new_pc         out  32     redirect target, valid only while flush=1
//  halted         out  1      pipeline frozen by debug halt
//  stall_timeout  out  1      sticky watchdog flag
//  stall_cycles   out  CNT_W  count of RUN cycles with stall!=0, saturating
//  flush_count    out  CNT_W  count of flush cycles, saturating
// BEHAVIOUR
//  - FSM states: RUN, HALT; reset -> RUN. All registered outputs are 0 in the
//    reset cycle and after it; flush=0, stall=0, new_pc=0 while rst=1.
//  - stall, flush and new_pc are combinational from inputs and state (0-cycle
//    latency). Downstream registers act on them at the next clk edge.
//  - RUN, priority highest first:
//    excepttype!=0    -> flush=1, stall=6'b000000
//                        new_pc = cp0_epc if excepttype==ERET_CODE, else EXC_VECTOR
//    stallreq_mem     -> stall=6'b011111
//    stallreq_ex      -> stall=6'b001111
//    stallreq_id      -> stall=6'b000111
//    stallreq_if      -> stall=6'b000111
//    none             -> stall=0, flush=0, new_pc=0
//  - RUN->HALT: at the edge where halt_req=1 && flush=0 && stallreq_mem=0.
//    An in-flight bus access always completes before the halt.
//  - HALT: stall=6'b111111, flush=0 (excepttype is ignored), halted=1.
//  - HALT->RUN: at the first edge with halt_req=0. halted=0 the following
//    cycle, and normal arbitration resumes in that same cycle.
//  - halted is registered and equals (state==HALT).
//  - Watchdog: run_cnt increments each RUN cycle with stall[0]=1.
//    It clears on stall[0]=0, on flush, or in HALT.
//    run_cnt==STALL_TIMEOUT-1 with stall[0]=1 sets stall_timeout, sticky until rst.
//    run_cnt saturates and does not wrap.
//  - stall_cycles: +1 on each RUN cycle with stall!=0.
//  - flush_count: +1 on each cycle with flush=1.
//  - Both counters hold at all-ones and are never decremented.
//    HALT cycles are not counted.
//  - Simultaneous events:
//    exception + any stallreq -> flush wins, no stall.
//    halt_req + exception -> flush that cycle, halt entry deferred.
//    rst in HALT -> RUN next cycle with all counters/flags 0.
// TESTING
//  1 stallreq_id=1 for 3 cycles -> stall=6'b000111 x3, then 0; stall_cycles=3
//  2 stallreq_mem=1 & stallreq_ex=1 together -> stall=6'b011111; drop mem -> 6'b001111
//  3 excepttype=32'h8 with stallreq_ex=1 -> flush=1, stall=0, new_pc=32'h20;
//    flush_count=1
//  4 excepttype=32'he, cp0_epc=32'h1000_0040 -> flush=1, new_pc=32'h1000_0040
//  5 halt_req=1 while stallreq_mem=1 for 2 cycles -> HALT entered 1 cycle
//    after mem drops; stall=6'h3f, halted=1; exception ignored; halt_req=0 -> RUN
//  6 STALL_TIMEOUT=8, stallreq_if held 8 cycles -> stall_timeout=1 after 8th;
//    stays 1 after request drops; rst clears it

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline controller for the 5-stage core: stall arbitration, exception/ERET redirect,
// debug halt sequencing, stall watchdog and saturating stall/flush counters.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE     = 32'h0000_000e,
  parameter int          STALL_TIMEOUT = 1024,
  parameter int          CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic [31:0]      excepttype,
  input  logic [31:0]      cp0_epc,
  input  logic             halt_req,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             halted,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // state | meaning
  // RUN   | normal arbitration of stall requests and exceptions
  // HALT  | debug halt, whole pipeline frozen, exceptions ignored
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  // One extra bit so the saturation ceiling always lies above STALL_TIMEOUT-1.
  localparam int WD_W = $clog2(STALL_TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(STALL_TIMEOUT - 1);

  state_t state, state_next;
  logic [WD_W-1:0] run_cnt;
  logic exc;

  assign exc = (excepttype != 32'h0);

  always_comb begin
    stall      = 6'b000000;
    flush      = 1'b0;
    new_pc     = 32'h0;
    state_next = state;
    if (!rst) begin
      case (state)
        RUN: begin
          if (exc) begin
            flush  = 1'b1;
            new_pc = (excepttype == ERET_CODE) ? cp0_epc : EXC_VECTOR;
          end else if (stallreq_mem) begin
            stall = 6'b011111;
          end else if (stallreq_ex) begin
            stall = 6'b001111;
          end else if (stallreq_id || stallreq_if) begin
            stall = 6'b000111;
          end
          // Never halt mid-redirect or with a data bus access outstanding.
          if (halt_req && !exc && !stallreq_mem) state_next = HALT;
        end
        HALT: begin
          stall = 6'b111111;
          if (!halt_req) state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  assign halted = (state == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt       <= '0;
      stall_timeout <= 1'b0;
    end else if (state == RUN && stall[0]) begin
      if (run_cnt == WD_LAST) stall_timeout <= 1'b1;
      if (run_cnt != '1)      run_cnt <= run_cnt + 1'b1;
    end else begin
      run_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (state == RUN && stall != 6'b000000 && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (flush && flush_count != '1)
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule
